// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (frame constants, state encoding,
//               parity helper) used by the transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Data bits per frame and line levels.
    localparam int   c_DATA_BITS  = 8;
    localparam logic c_IDLE_LEVEL = 1'b1;
    localparam int   c_STOP_BITS  = 1;

    // Frame state machine encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity of the byte, inverted when odd parity is selected.
    function automatic logic calc_parity(input logic [c_DATA_BITS-1:0] data,
                                         input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-time counter. Emits a one-cycle tick on the last cycle of
//               every CLKS_PER_BIT-cycle bit period; clear restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int                 c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; held at zero while cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // The tick marks the final cycle of the bit, so the next edge starts a new bit.
    assign tick = !clear && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8 data bits LSB first, optional even/odd
//               parity, one stop bit. Serial line is driven from a register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int               c_IDX_W    = $clog2(c_DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_DATA_BITS - 1);

    uart_state_e              r_state;
    uart_state_e              w_state_next;
    logic [c_DATA_BITS-1:0]   r_shift;
    logic [c_IDX_W-1:0]       r_idx;
    logic                     r_parity;
    logic                     r_tx;
    logic                     w_tx_next;
    logic                     w_accept;
    logic                     w_tick;
    logic                     w_bit_clear;

    assign w_accept    = tx_valid && (r_state == ST_IDLE);
    assign w_bit_clear = (r_state == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (w_bit_clear),
        .tick  (w_tick)
    );

    // State, line register and data path; byte and its parity are captured on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_tx     <= c_IDLE_LEVEL;
            r_shift  <= '0;
            r_idx    <= '0;
            r_parity <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            if (w_accept) begin
                r_shift  <= tx_data;
                r_parity <= calc_parity(tx_data, PARITY_ODD != 0);
                r_idx    <= '0;
            end else if ((r_state == ST_DATA) && w_tick) begin
                r_shift <= r_shift >> 1;
                r_idx   <= r_idx + c_IDX_W'(1);
            end
        end
    end

    // Next state and the level the line takes at the next bit boundary.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_tx_next    = ~c_IDLE_LEVEL;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_idx == c_LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = c_IDLE_LEVEL;
                        end
                    end else begin
                        // Shift happens on this same edge, so bit 1 is the next LSB.
                        w_tx_next = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = c_IDLE_LEVEL;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                    w_tx_next    = c_IDLE_LEVEL;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = c_IDLE_LEVEL;
            end
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = ~tx_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx: three instances (no parity,
//               even parity, odd parity) compared cycle by cycle against a
//               frame model built from the serial-format rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] busy;
    logic [2:0] line;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    uart_tx #(.CLKS_PER_BIT(c_CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_none (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx(line[0]), .busy(busy[0]));

    uart_tx #(.CLKS_PER_BIT(c_CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx(line[1]), .busy(busy[1]));

    uart_tx #(.CLKS_PER_BIT(c_CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx(line[2]), .busy(busy[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Frame length in bit times: start + 8 data + optional parity + stop.
    function automatic int frame_bits(input int sel);
        return (sel == 0) ? 10 : 11;
    endfunction

    // Expected line level for bit position b of a frame carrying d.
    function automatic logic exp_bit(input int sel, input logic [7:0] d, input int b);
        logic par;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (sel != 0 && b == 9) begin
            par = (($countones(d) % 2) == 1);
            if (sel == 2) par = !par;
            return par;
        end
        return 1'b1;
    endfunction

    // Offer byte d to instance sel, then check every cycle of the frame.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic [7:0] post_d,
                              input bit keep_valid, input int glitch_k, input int abort_k,
                              output int acc_cyc);
        int n;
        int waited;
        n = frame_bits(sel) * c_CPB;
        waited = 0;
        while (ready[sel] !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("s%0d_ready_before_accept", sel), 32'(ready[sel]), 32'd1);
        tx_data    = d;
        valid[sel] = 1'b1;
        acc_cyc    = cyc + 1;
        @(negedge clk);
        for (int k = 1; k <= n; k++) begin
            check($sformatf("s%0d_d%02h_tx_k%0d", sel, d, k), 32'(line[sel]),
                  32'(exp_bit(sel, d, (k - 1) / c_CPB)));
            check($sformatf("s%0d_ready_busy_k%0d", sel, k), 32'({ready[sel], busy[sel]}), 32'h1);
            if (k == 1) begin
                tx_data    = post_d;
                valid[sel] = keep_valid;
            end
            if (glitch_k > 0 && k == glitch_k) begin
                tx_data    = 8'h00;
                valid[sel] = 1'b1;
            end
            if (glitch_k > 0 && k == glitch_k + 1) valid[sel] = 1'b0;
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                check("abort_tx", 32'(line[sel]), 32'd1);
                check("abort_ready", 32'(ready[sel]), 32'd1);
                check("abort_busy", 32'(busy[sel]), 32'd0);
                return;
            end
            @(negedge clk);
        end
        check($sformatf("s%0d_end_ready_busy_tx", sel),
              32'({ready[sel], busy[sel], line[sel]}), 32'h5);
    endtask

    initial begin
        int a0;
        int a1;
        int sel;
        int gap;
        int gk;
        logic [7:0] d;
        logic [7:0] pd;

        reset   = 1'b1;
        tx_data = 8'h00;
        valid   = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(line), 32'h7);
        check("rst_ready", 32'(ready), 32'h7);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Plain frame, then even and odd parity frames.
        send_frame(0, 8'hA5, 8'hA5, 1'b0, 0, 0, a0);
        send_frame(1, 8'h07, 8'h07, 1'b0, 0, 0, a0);
        send_frame(2, 8'h07, 8'h07, 1'b0, 0, 0, a0);

        // Back-to-back with tx_valid held high.
        send_frame(0, 8'h55, 8'hFF, 1'b1, 0, 0, a0);
        send_frame(0, 8'hFF, 8'hFF, 1'b0, 0, 0, a1);
        check("b2b_spacing", 32'(a1 - a0), 32'(10 * c_CPB + 1));

        // Valid pulse while busy must not start another frame.
        send_frame(0, 8'h3A, 8'h3A, 1'b0, 13, 0, a0);
        for (int i = 0; i < 12; i++) begin
            check("no_extra_frame", 32'({ready[0], line[0]}), 32'h3);
            @(negedge clk);
        end

        // Input data changing after accept must not alter the frame.
        send_frame(0, 8'h00, 8'hFF, 1'b0, 0, 0, a0);

        // Reset during DATA bit 3, then a clean frame right after release.
        send_frame(0, 8'hC3, 8'hC3, 1'b0, 0, 4 * c_CPB + 2, a0);
        @(negedge clk);
        check("in_reset_tx", 32'(line), 32'h7);
        reset = 1'b0;
        send_frame(0, 8'h3C, 8'h3C, 1'b0, 0, 0, a0);

        // Randomized traffic across the three instances.
        for (int it = 0; it < 12; it++) begin
            sel = int'($urandom_range(0, 2));
            d   = 8'($urandom);
            pd  = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            gk  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0;
            repeat (gap) @(negedge clk);
            send_frame(sel, d, pd, 1'b0, gk, 0, a0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit time (legal range 2..65535).
REQ-002 The block SHALL have parameter PARITY_EN, default 0, where 1 inserts a parity bit after the data bits.
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity (ignored when PARITY_EN=0).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port tx_data, input, 8 bits: byte to transmit, sampled only on accept.
REQ-007 The block SHALL have port tx_valid, input, 1 bit: tx_data holds a byte to send.
REQ-008 The block SHALL have port tx_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-011 Accept SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data is latched into an internal shift register at that edge.
REQ-012 tx_ready SHALL be 1 exactly when the state is IDLE; busy SHALL be its complement.
REQ-013 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 Transition IDLE->START SHALL occur on accept; tx=0 from the cycle after accept.
REQ-015 Each of START, each DATA bit, PARITY and STOP SHALL hold tx stable for exactly CLKS_PER_BIT cycles, timed by a bit counter reset to 0 at each bit start.
REQ-016 DATA SHALL send 8 bits LSB first; a 3-bit index counts 0..7, and after bit 7 the block goes to PARITY if PARITY_EN=1, else STOP.
REQ-017 The PARITY bit SHALL be the XOR of the 8 latched bits, inverted when PARITY_ODD=1.
REQ-018 STOP SHALL drive tx=1 for one bit time, then go to IDLE; tx stays 1 in IDLE.
REQ-019 Frame length SHALL be 10 bit times (11 with parity); the minimum accept-to-accept spacing is frame_bits*CLKS_PER_BIT+1 cycles.
REQ-020 tx_valid while not ready SHALL be ignored; changes to tx_data after accept SHALL NOT affect the frame in flight.
REQ-021 tx SHALL be driven from a register (glitch-free), never combinationally.

Reset
REQ-022 On reset assertion, the block SHALL immediately force: state=IDLE, tx=1, tx_ready=1, busy=0, bit and index counters=0, shift register=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no completion of stop or parity; after release the block SHALL accept a new byte on the first edge.

Structure
REQ-024 Shared package uart_pkg SHALL hold the state enumeration, DATA_BITS=8, the idle line level, and the stop-bit count, shared with the receiver.
REQ-025 The bit-time counter SHALL be a sub-module uart_baud_tick (clear input, tick output pulsing every CLKS_PER_BIT cycles).

Verification
REQ-026 Scenario: CLKS_PER_BIT=4, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; tx_ready returns 1 after 40 cycles.
REQ-027 Scenario: PARITY_EN=1 and PARITY_ODD=0, send 0x07 -> parity bit=1; with PARITY_ODD=1, send 0x07 -> parity bit=0; frame lasts 11 bit times.
REQ-028 Scenario: back-to-back, tx_valid held high with 0x55 then 0xFF -> second accept exactly 41 cycles after the first (CLKS_PER_BIT=4); no idle gap beyond one cycle.
REQ-029 Scenario: tx_valid pulsed with 0x00 while busy -> ignored, with no extra frame emitted.
REQ-030 Scenario: reset asserted during DATA bit 3 -> tx=1 and tx_ready=1 without waiting for a clock edge; the next byte 0x3C then transmits correctly.
REQ-031 Scenario: tx_data changed to 0xFF on the cycle after accepting 0x00 -> all 8 serial data bits are 0.
